// File: rtl/i2s_rx_capture.sv
// Philips I2S receiver: oversamples sclk/lrck/sdin in the system clock domain and
// deserialises MSB-first stereo words into parallel left/right samples.
`timescale 1ns / 1ps
module i2s_rx_capture #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_50MHz,
  input  logic             reset,
  input  logic             i2s_sclk,
  input  logic             i2s_lrck,
  input  logic             i2s_sdin,
  input  logic             error_clr,
  output logic [WIDTH-1:0] L_data,
  output logic [WIDTH-1:0] R_data,
  output logic             sample_valid,
  output logic             frame_error
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned IdxW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntMax  = CntW'(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam logic [IdxW-1:0] IdxTop  = IdxW'(WIDTH - 1);

  typedef enum logic [0:0] {StAlign, StRun} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, lrck_sync_q, sdin_sync_q;
  logic                   sclk_s, lrck_s, sdin_s;
  logic                   sclk_d_q, rise_q, lr_q, bit_q;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d, shift_in;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]  bit_idx;
  logic             lr_prev_q, lr_prev_d;
  logic             got_l_q, got_l_d;
  logic [WIDTH-1:0] l_data_q, l_data_d, r_data_q, r_data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             boundary, short_word;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign lrck_s = lrck_sync_q[SYNC_STAGES-1];
  assign sdin_s = sdin_sync_q[SYNC_STAGES-1];

  // The rise strobe and its lr/bit samples are registered together so the word
  // logic sees one aligned sample per sclk rise.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      sclk_sync_q <= '0;
      lrck_sync_q <= '0;
      sdin_sync_q <= '0;
      sclk_d_q    <= 1'b0;
      rise_q      <= 1'b0;
      lr_q        <= 1'b0;
      bit_q       <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i2s_sclk};
      lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], i2s_lrck};
      sdin_sync_q <= {sdin_sync_q[SYNC_STAGES-2:0], i2s_sdin};
      sclk_d_q    <= sclk_s;
      rise_q      <= sclk_s & ~sclk_d_q;
      lr_q        <= lrck_s;
      bit_q       <= sdin_s;
    end
  end

  // Bits land left-justified, so a short word is already zero-padded in its LSBs.
  always_comb begin
    bit_idx  = IdxTop - cnt_q[IdxW-1:0];
    shift_in = shift_q;
    if (cnt_q < CntMax) begin
      shift_in[bit_idx] = bit_q;
    end
  end

  assign boundary   = rise_q && (lr_q != lr_prev_q);
  assign short_word = (cnt_q < CntLast);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    lr_prev_d = lr_prev_q;
    got_l_d   = got_l_q;
    l_data_d  = l_data_q;
    r_data_d  = r_data_q;
    valid_d   = 1'b0;
    err_d     = err_q;

    if (error_clr) begin
      err_d = 1'b0;
    end

    if (rise_q) begin
      lr_prev_d = lr_q;
      if (boundary) begin
        shift_d = '0;
        cnt_d   = '0;
        unique case (state_q)
          StAlign: begin
            // The word ending at an R->L edge is dropped; the L word after it is the first kept.
            if (lr_prev_q) begin
              state_d = StRun;
            end
          end
          StRun: begin
            if (short_word) begin
              err_d = 1'b1;
            end
            if (lr_prev_q) begin
              r_data_d = shift_in;
              valid_d  = got_l_q;
            end else begin
              l_data_d = shift_in;
              got_l_d  = 1'b1;
            end
          end
          default: state_d = StAlign;
        endcase
      end else if (cnt_q < CntMax) begin
        shift_d = shift_in;
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q   <= StAlign;
      shift_q   <= '0;
      cnt_q     <= '0;
      lr_prev_q <= 1'b0;
      got_l_q   <= 1'b0;
      l_data_q  <= '0;
      r_data_q  <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      lr_prev_q <= lr_prev_d;
      got_l_q   <= got_l_d;
      l_data_q  <= l_data_d;
      r_data_q  <= r_data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign L_data       = l_data_q;
  assign R_data       = r_data_q;
  assign sample_valid = valid_q;
  assign frame_error  = err_q;

endmodule
